// File: rtl/bin_to_bcd_seq.sv
// Sequential binary-to-BCD converter: takes the magnitude of an unsigned or two's-complement
// word and runs double-dabble on it, one shift per clock, then presents BCD digits and a sign.
module bin_to_bcd_seq #(
    parameter int WIDTH  = 10,
    parameter int DIGITS = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  start,
    input  logic                  unsigned_mode,
    input  logic [WIDTH-1:0]      value_in,
    output logic                  busy,
    output logic                  done,
    output logic                  negative,
    output logic [4*DIGITS-1:0]   bcd
);

    localparam int BW = 4 * DIGITS;
    localparam int CW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_t;

    state_t          state;
    logic [WIDTH-1:0] mag;
    logic [BW-1:0]    scratch;
    logic [BW-1:0]    adj;
    logic [BW-1:0]    next_scratch;
    logic [CW-1:0]    count;
    logic             sign_r;

    // One double-dabble step: add-3 correction, then shift in the next magnitude bit.
    always_comb begin
        // NOTE: every always_comb output gets a default first so no latch is inferred.
        adj = scratch;
        for (int d = 0; d < DIGITS; d++) begin
            if (scratch[4*d +: 4] >= 4'd5) begin
                adj[4*d +: 4] = scratch[4*d +: 4] + 4'd3;
            end
        end
        next_scratch = BW'({adj, mag[WIDTH-1]});
    end

    // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            state    <= IDLE;
            busy     <= 1'b0;
            done     <= 1'b0;
            negative <= 1'b0;
            bcd      <= '0;
            mag      <= '0;
            scratch  <= '0;
            count    <= '0;
            sign_r   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    done <= 1'b0;
                    if (start) begin
                        sign_r  <= !unsigned_mode && value_in[WIDTH-1];
                        mag     <= (!unsigned_mode && value_in[WIDTH-1])
                                   ? (~value_in) + WIDTH'(1) : value_in;
                        scratch <= '0;
                        count   <= '0;
                        busy    <= 1'b1;
                        state   <= SHIFT;
                    end
                end
                SHIFT: begin
                    scratch <= next_scratch;
                    mag     <= {mag[WIDTH-2:0], 1'b0};
                    count   <= count + CW'(1);
                    // Final shift: publish the result so it is visible during the DONE cycle.
                    if (count == CW'(WIDTH - 1)) begin
                        bcd      <= next_scratch;
                        negative <= sign_r;
                        done     <= 1'b1;
                        state    <= DONE;
                    end
                end
                DONE: begin
                    done  <= 1'b0;
                    busy  <= 1'b0;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bin_to_bcd_seq.sv
// Scoreboard bench for bin_to_bcd_seq: expected results are queued at start and
// compared by a monitor whenever done pulses.
module tb_bin_to_bcd_seq;

    localparam int WIDTH  = 10;
    localparam int DIGITS = 4;

    logic                clk = 1'b0;
    logic                rst;
    logic                start;
    logic                unsigned_mode;
    logic [WIDTH-1:0]    value_in;
    logic                busy;
    logic                done;
    logic                negative;
    logic [4*DIGITS-1:0] bcd;

    typedef struct packed {
        logic        neg;
        logic [15:0] bcd;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;
    int   errors     = 0;
    int   checks     = 0;
    int   done_count = 0;
    logic prev_done  = 1'b0;

    bin_to_bcd_seq #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .unsigned_mode(unsigned_mode),
        .value_in     (value_in),
        .busy         (busy),
        .done         (done),
        .negative     (negative),
        .bcd          (bcd)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // Decimal reference: magnitude by integer arithmetic, digits by division.
    function automatic exp_t ref_model(input logic [WIDTH-1:0] v, input logic um);
        exp_t r;
        int   m;
        r.neg = !um && v[WIDTH-1];
        m = r.neg ? (1 << WIDTH) - int'(v) : int'(v);
        r.bcd = '0;
        for (int i = 0; i < DIGITS; i++) begin
            r.bcd[4*i +: 4] = 4'(m % 10);
            m = m / 10;
        end
        return r;
    endfunction

    // Monitor: pops the scoreboard on every done pulse and checks pulse width.
    always @(negedge clk) begin
        if (done === 1'b1) begin
            done_count++;
            checks++;
            if (prev_done !== 1'b0) begin
                errors++;
                $display("FAIL done_width: done high in two consecutive cycles at %0t", $time);
            end
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_done: got neg=%0b bcd=%h, no result expected", negative, bcd);
            end else begin
                mon_e = exp_q.pop_front();
                if ({negative, bcd} !== mon_e) begin
                    errors++;
                    $display("FAIL result: got neg=%0b bcd=%h, expected neg=%0b bcd=%h",
                             negative, bcd, mon_e.neg, mon_e.bcd);
                end
            end
        end
        prev_done = done;
    end

    task automatic conv(input logic [WIDTH-1:0] v, input logic um, input exp_t e);
        int lat;
        exp_q.push_back(e);
        @(negedge clk);
        value_in      = v;
        unsigned_mode = um;
        start         = 1'b1;
        @(negedge clk);
        start         = 1'b0;
        value_in      = WIDTH'($urandom);
        unsigned_mode = 1'($urandom);
        lat = 1;
        while (done !== 1'b1 && lat < 20) begin
            @(negedge clk);
            lat++;
        end
        checks++;
        if (lat != WIDTH + 1) begin
            errors++;
            $display("FAIL latency: value=%h mode=%0b got %0d cycles, expected %0d", v, um, lat, WIDTH + 1);
        end
    endtask

    task automatic test_reset;
        rst = 1'b1;
        start = 1'b0;
        unsigned_mode = 1'b0;
        value_in = '0;
        repeat (2) @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            errors++;
            $display("FAIL reset_ctrl: busy=%b done=%b, expected 0 0", busy, done);
        end
        checks++;
        if (negative !== 1'b0 || bcd !== 16'h0000) begin
            errors++;
            $display("FAIL reset_data: neg=%b bcd=%h, expected 0 0000", negative, bcd);
        end
        rst = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_basic;
        conv(10'b0000001111, 1'b1, '{neg: 1'b0, bcd: 16'h0015});
        conv(10'b0000001111, 1'b0, '{neg: 1'b0, bcd: 16'h0015});
        conv(10'b1111111111, 1'b0, '{neg: 1'b1, bcd: 16'h0001});
        conv(10'b1000000000, 1'b1, '{neg: 1'b0, bcd: 16'h0512});
        conv(10'b1000000000, 1'b0, '{neg: 1'b1, bcd: 16'h0512});
        conv(10'b0000000000, 1'b0, '{neg: 1'b0, bcd: 16'h0000});
        conv(10'b1111111111, 1'b1, '{neg: 1'b0, bcd: 16'h1023});
        // Result must hold while inputs wander and no conversion runs.
        repeat (6) begin
            @(negedge clk);
            value_in = WIDTH'($urandom);
            unsigned_mode = 1'($urandom);
        end
        checks++;
        if (bcd !== 16'h1023 || negative !== 1'b0) begin
            errors++;
            $display("FAIL hold: neg=%b bcd=%h, expected 0 1023", negative, bcd);
        end
    endtask

    task automatic test_back_to_back;
        int dc0;
        int pos[3];
        int n;
        dc0 = done_count;
        n = 0;
        for (int i = 0; i < 3; i++) exp_q.push_back('{neg: 1'b0, bcd: 16'h0002});
        @(negedge clk);
        value_in = 10'b0000000010;
        unsigned_mode = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 60; c++) begin
            @(negedge clk);
            if (c == 30) start = 1'b0;
            if (done === 1'b1 && n < 3) begin
                pos[n] = c;
                n++;
            end
        end
        checks++;
        if (done_count - dc0 != 3) begin
            errors++;
            $display("FAIL b2b_count: got %0d done pulses, expected 3", done_count - dc0);
        end
        checks++;
        if (n != 3 || pos[0] != WIDTH + 1 || pos[1] - pos[0] != WIDTH + 2 || pos[2] - pos[1] != WIDTH + 2) begin
            errors++;
            $display("FAIL b2b_period: pulses=%0d at %0d %0d %0d, expected 11 23 35", n, pos[0], pos[1], pos[2]);
        end
    endtask

    task automatic test_busy_ignore;
        int dc0;
        dc0 = done_count;
        exp_q.push_back('{neg: 1'b0, bcd: 16'h0021});
        @(negedge clk);
        value_in = 10'd21;
        unsigned_mode = 1'b1;
        start = 1'b1;
        for (int c = 1; c <= 30; c++) begin
            @(negedge clk);
            start = 1'b0;
            if (c == 1 || c == 11) begin
                checks++;
                if (busy !== 1'b1) begin
                    errors++;
                    $display("FAIL busy_high: cycle %0d busy=%b, expected 1", c, busy);
                end
            end
            if (c == 12) begin
                checks++;
                if (busy !== 1'b0) begin
                    errors++;
                    $display("FAIL busy_low: cycle %0d busy=%b, expected 0", c, busy);
                end
            end
            if (c == 3 || c == 7) begin
                start = 1'b1;
                value_in = 10'd999;
            end
            if (done === 1'b1) begin
                start = 1'b1;
                value_in = 10'd500;
            end
        end
        checks++;
        if (done_count - dc0 != 1) begin
            errors++;
            $display("FAIL busy_ignore: got %0d done pulses, expected 1", done_count - dc0);
        end
    endtask

    task automatic test_reset_abort;
        int dc0;
        dc0 = done_count;
        @(negedge clk);
        value_in = 10'd1023;
        unsigned_mode = 1'b1;
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        repeat (5) @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || bcd !== 16'h0000 || negative !== 1'b0) begin
            errors++;
            $display("FAIL abort_state: busy=%b done=%b neg=%b bcd=%h, expected 0 0 0 0000",
                     busy, done, negative, bcd);
        end
        rst = 1'b0;
        repeat (20) @(negedge clk);
        checks++;
        if (done_count != dc0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL abort_no_done: got %0d done pulses busy=%b, expected 0 and 0",
                     done_count - dc0, busy);
        end
    endtask

    task automatic test_sweep;
        for (int um = 0; um < 2; um++) begin
            for (int v = 0; v < (1 << WIDTH); v++) begin
                conv(WIDTH'(v), 1'(um), ref_model(WIDTH'(v), 1'(um)));
            end
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_back_to_back();
        test_busy_ignore();
        test_reset_abort();
        test_sweep();
        repeat (3) @(negedge clk);
        checks++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL scoreboard_drain: %0d results never produced", exp_q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
